// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator: pixel-rate enable, pixel/line counters,
// registered zero-skew sync outputs, visible-area decode and frame-start pulse.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_true,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Thresholds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be >= 2");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H/V totals must fit 10-bit counters");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        p_tick_d      = (div_q == DIV_LAST);
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        if (p_tick_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs decode the next-state counters so they toggle on the same edge as x/y.
        hsync_d = !(({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END));
        vsync_d = !(({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END));
    end

    // NOTE: state registers use non-blocking assignments only; every flop has an
    // explicit reset value so the outputs are defined the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            p_tick_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            p_tick_q      <= p_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick       = p_tick_q;
    assign x            = x_q;
    assign y            = y_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign frame_start  = frame_start_q;
    assign display_true = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line-level timing and a short-line
// instance (real vertical timing) so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int DA = 4, HDA = 640, HFA = 16, HSA = 96, HBA = 48;
    localparam int DB = 2, HDB = 8,   HFB = 2,  HSB = 3,  HBB = 3;
    localparam int VD = 480, VF = 10, VS = 2, VB = 33;
    localparam int HTB = HDB + HFB + HSB + HBB;
    localparam int FRAME_B = HTB * (VD + VF + VS + VB) * DB;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    localparam obs_t RST_OBS = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, disp: 1'b1,
                                 hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    logic       pt_a, dt_a, hs_a, vs_a, fs_a, pt_b, dt_b, hs_b, vs_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    obs_t       obs_a, obs_b;
    assign obs_a = {pt_a, x_a, y_a, dt_a, hs_a, vs_a, fs_a};
    assign obs_b = {pt_b, x_b, y_b, dt_b, hs_b, vs_b, fs_b};

    vga_sync_gen u_dut_a (
        .clk(clk), .rst_n(rst_a_n), .p_tick(pt_a), .x(x_a), .y(y_a),
        .display_true(dt_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .CLK_DIV(DB), .H_DISPLAY(HDB), .H_FRONT(HFB), .H_SYNC(HSB), .H_BACK(HBB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .p_tick(pt_b), .x(x_b), .y(y_b),
        .display_true(dt_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int k_a = 0;
    int k_b = 0;

    // Rising edges since each instance left reset; the reference model is indexed by this.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        k_a <= rst_a_n ? k_a + 1 : 0;
        k_b <= rst_b_n ? k_b + 1 : 0;
    end

    // Expected outputs after k rising edges from release: pixel p spans edges p*d+1 .. (p+1)*d.
    function automatic obs_t model(int k, int d, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        obs_t o;
        int ht, vt, adv, p, px, py;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        adv = (k < 1) ? 0 : (k - 1) / d;
        p   = adv % (ht * vt);
        px  = p % ht;
        py  = p / ht;
        o.p_tick = (k >= 1) && (k % d == 0);
        o.x      = 10'(px);
        o.y      = 10'(py);
        o.disp   = (px < hd) && (py < vd);
        o.hs     = !((px >= hd + hf) && (px < hd + hf + hs));
        o.vs     = !((py >= vd + vf) && (py < vd + vf + vs));
        o.fs     = (adv > 0) && ((k - 1) % d == 0) && (p == 0);
        return o;
    endfunction

    function automatic obs_t model_a(int k);
        return model(k, DA, HDA, HFA, HSA, HBA, VD, VF, VS, VB);
    endfunction

    function automatic obs_t model_b(int k);
        return model(k, DB, HDB, HFB, HSB, HBB, VD, VF, VS, VB);
    endfunction

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (obs_a !== RST_OBS) begin
            tests_failed++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, RST_OBS);
        end
        tests_run++;
        if (obs_b !== RST_OBS) begin
            tests_failed++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, RST_OBS);
        end
    endtask

    task automatic run_model_a(input string name, input int n);
        bit bad = 0;
        obs_t exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp = model_a(k_a);
            if (!bad && obs_a !== exp) begin
                bad = 1;
                $display("FAIL %s k=%0d got x=%0d y=%0d bits=%h exp x=%0d y=%0d bits=%h",
                         name, k_a, obs_a.x, obs_a.y, obs_a, exp.x, exp.y, exp);
            end
        end
        tests_run++;
        if (bad) tests_failed++;
    endtask

    task automatic test_free_run;
        @(negedge clk);
        rst_a_n = 1'b1;
        run_model_a("free_run_a", 3200 + int'($urandom_range(0, 800)));
    endtask

    task automatic wait_hs_a(input logic lvl, output int t, output logic [9:0] xv, output bit ok);
        logic prev;
        ok   = 0;
        t    = 0;
        xv   = '0;
        prev = hs_a;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (hs_a === lvl && prev !== lvl) begin
                t  = cyc;
                xv = x_a;
                ok = 1;
                break;
            end
            prev = hs_a;
        end
    endtask

    task automatic test_line_timing;
        int t_fall, t_rise, t_fall2;
        logic [9:0] x_fall, x_rise, x_fall2;
        bit ok1, ok2, ok3;
        wait_hs_a(1'b0, t_fall, x_fall, ok1);
        wait_hs_a(1'b1, t_rise, x_rise, ok2);
        wait_hs_a(1'b0, t_fall2, x_fall2, ok3);
        tests_run++;
        if (!(ok1 && ok2 && ok3)) begin
            tests_failed++;
            $display("FAIL hsync_edges_timeout seen=%0d%0d%0d exp=111", ok1, ok2, ok3);
        end
        tests_run++;
        if (x_fall !== 10'd656 || x_rise !== 10'd752) begin
            tests_failed++;
            $display("FAIL hsync_edge_x fall=%0d rise=%0d exp 656/752", x_fall, x_rise);
        end
        tests_run++;
        if (t_rise - t_fall != 384) begin
            tests_failed++;
            $display("FAIL hsync_low_clks got=%0d exp=384", t_rise - t_fall);
        end
        tests_run++;
        if (t_fall2 - t_fall != 3200) begin
            tests_failed++;
            $display("FAIL line_period_clks got=%0d exp=3200", t_fall2 - t_fall);
        end
    endtask

    task automatic test_reset_mid_line;
        bit found = 0;
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            if (x_a == 10'd300) begin
                found = 1;
                break;
            end
        end
        #($urandom_range(1, 3));
        rst_a_n = 1'b0;
        #1;
        tests_run++;
        if (!found || obs_a !== RST_OBS) begin
            tests_failed++;
            $display("FAIL reset_mid_line found=%0d got=%h exp=%h", found, obs_a, RST_OBS);
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rst_a_n = 1'b1;
        run_model_a("after_reset_a", 40 + int'($urandom_range(0, 40)));
    endtask

    task automatic test_visible_window_a;
        bit seen639 = 0, seen640 = 0, seen799 = 0;
        logic d639 = 1'b0, d640 = 1'b1, d799 = 1'b1;
        for (int i = 0; i < 3300 && !seen799; i++) begin
            @(negedge clk);
            if (y_a == 10'd0 && x_a == 10'd639) begin seen639 = 1; d639 = dt_a; end
            if (y_a == 10'd0 && x_a == 10'd640) begin seen640 = 1; d640 = dt_a; end
            if (y_a == 10'd0 && x_a == 10'd799) begin seen799 = 1; d799 = dt_a; end
        end
        tests_run++;
        if (!seen639 || d639 !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_639_0 seen=%0d got=%b exp=1", seen639, d639);
        end
        tests_run++;
        if (!seen640 || d640 !== 1'b0) begin
            tests_failed++;
            $display("FAIL disp_640_0 seen=%0d got=%b exp=0", seen640, d640);
        end
        tests_run++;
        if (!seen799 || d799 !== 1'b0) begin
            tests_failed++;
            $display("FAIL disp_799_0 seen=%0d got=%b exp=0", seen799, d799);
        end
    endtask

    task automatic test_reset_mid_frame_b;
        bit found = 0;
        logic [9:0] xr;
        xr = 10'($urandom_range(0, HTB - 1));
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (y_b == 10'd100 && x_b == xr) begin
                found = 1;
                break;
            end
        end
        #2;
        rst_b_n = 1'b0;
        #1;
        tests_run++;
        if (!found || obs_b !== RST_OBS) begin
            tests_failed++;
            $display("FAIL reset_mid_frame_b found=%0d got=%h exp=%h", found, obs_b, RST_OBS);
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic test_frame_b;
        bit bad = 0, wrap_ok = 1, back_to_back = 0;
        int fs_cnt = 0, vs_ticks = 0, t_fs1 = 0, t_fs2 = 0, early_fs = 0;
        logic [9:0] px = '0, py = '0;
        logic prev_fs = 1'b0;
        bit s_in = 0, s_x = 0, s_y = 0, s_end = 0;
        logic d_in = 1'b0, d_x = 1'b1, d_y = 1'b1, d_end = 1'b1;
        obs_t exp;
        rst_b_n = 1'b1;
        for (int i = 0; i < 2 * FRAME_B + 1 + int'($urandom_range(1, 50)); i++) begin
            @(negedge clk);
            exp = model_b(k_b);
            if (!bad && obs_b !== exp) begin
                bad = 1;
                $display("FAIL frame_model_b k=%0d got x=%0d y=%0d bits=%h exp x=%0d y=%0d bits=%h",
                         k_b, obs_b.x, obs_b.y, obs_b, exp.x, exp.y, exp);
            end
            if (fs_b === 1'b1) begin
                fs_cnt++;
                if (prev_fs === 1'b1) back_to_back = 1;
                if (k_b <= 3 * DB) early_fs++;
                if (fs_cnt == 1) t_fs1 = cyc;
                if (fs_cnt == 2) t_fs2 = cyc;
                if (px != 10'(HTB - 1) || py != 10'd524 || x_b != 10'd0 || y_b != 10'd0)
                    wrap_ok = 0;
            end
            if (k_b <= FRAME_B && pt_b === 1'b1 && vs_b === 1'b0) vs_ticks++;
            if (!s_in  && x_b == 10'(HDB - 1) && y_b == 10'd479) begin s_in  = 1; d_in  = dt_b; end
            if (!s_x   && x_b == 10'(HDB)     && y_b == 10'd0)   begin s_x   = 1; d_x   = dt_b; end
            if (!s_y   && x_b == 10'd0        && y_b == 10'd480) begin s_y   = 1; d_y   = dt_b; end
            if (!s_end && x_b == 10'(HTB - 1) && y_b == 10'd524) begin s_end = 1; d_end = dt_b; end
            prev_fs = fs_b;
            px = x_b;
            py = y_b;
        end
        tests_run++;
        if (bad) tests_failed++;
        tests_run++;
        if (fs_cnt != 2 || back_to_back || early_fs != 0) begin
            tests_failed++;
            $display("FAIL frame_start_pulses got=%0d wide=%0d early=%0d exp 2/0/0",
                     fs_cnt, back_to_back, early_fs);
        end
        tests_run++;
        if (!wrap_ok) begin
            tests_failed++;
            $display("FAIL wrap_to_origin got prev=(%0d,%0d) exp prev=(%0d,524) then (0,0)",
                     px, py, HTB - 1);
        end
        tests_run++;
        if (t_fs2 - t_fs1 != FRAME_B) begin
            tests_failed++;
            $display("FAIL frame_period_clks got=%0d exp=%0d", t_fs2 - t_fs1, FRAME_B);
        end
        tests_run++;
        if (vs_ticks != 2 * HTB) begin
            tests_failed++;
            $display("FAIL vsync_low_ticks got=%0d exp=%0d", vs_ticks, 2 * HTB);
        end
        tests_run++;
        if (!(s_in && s_x && s_y && s_end) || d_in !== 1'b1 || d_x !== 1'b0 ||
            d_y !== 1'b0 || d_end !== 1'b0) begin
            tests_failed++;
            $display("FAIL visible_window_b seen=%0d%0d%0d%0d got=%b%b%b%b exp=1000",
                     s_in, s_x, s_y, s_end, d_in, d_x, d_y, d_end);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_line_timing();
        test_reset_mid_line();
        test_visible_window_a();
        test_reset_mid_frame_b();
        test_frame_b();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
